// File: rtl/pe_rs_if.sv
// Stream channels between the GLB side and one row-stationary PE.
// The PE attaches through the slave modport; the GLB/array side uses master.
interface pe_rs_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] ifmap;
    logic [DATA_W-1:0] filter;
    logic [DATA_W-1:0] ipsum;
    logic [DATA_W-1:0] opsum;
    logic              ifmap_valid;
    logic              ifmap_ready;
    logic              filter_valid;
    logic              filter_ready;
    logic              ipsum_valid;
    logic              ipsum_ready;
    logic              opsum_valid;
    logic              opsum_ready;

    modport master (
        output ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        input  ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );
    modport slave (
        input  ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        output ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );
endinterface

// File: rtl/pe_rs_param.sv
// Parametrised row-stationary PE: loads filter/ifmap/ipsum spads, runs one MAC per
// cycle over a sliding ifmap window, and streams opsums with optional ReLU.
module pe_rs_param #(
    parameter int DATA_W       = 32,
    parameter int ELEM_W       = 8,
    parameter int PSUM_W       = 32,
    parameter int IFMAP_DEPTH  = 12,
    parameter int FILTER_DEPTH = 48,
    parameter int PSUM_DEPTH   = 8,
    parameter int IFMAP_ZP     = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PE_en,
    input  logic [2:0] cfg_rs,
    input  logic [3:0] cfg_p,
    input  logic [3:0] cfg_q,
    input  logic [5:0] cfg_f,
    input  logic       cfg_relu,
    pe_rs_if.slave     bus,
    output logic       busy,
    output logic       cfg_err
);
    localparam int PACK = DATA_W / ELEM_W;
    localparam int IE_W = ELEM_W + 1;
    localparam int PR_W = ELEM_W + IE_W;
    localparam int FA_W = $clog2(FILTER_DEPTH);
    localparam int IA_W = $clog2(IFMAP_DEPTH);
    localparam int PA_W = $clog2(PSUM_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILT = 3'd1;
    localparam logic [2:0] S_IFM  = 3'd2;
    localparam logic [2:0] S_IPS  = 3'd3;
    localparam logic [2:0] S_CONV = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [2:0]               rs_q, rs_d;
    logic [3:0]               p_q, p_d, cq_q, cq_d, c_q, c_d, po_q, po_d;
    logic [5:0]               f_q, f_d, col_q, col_d;
    logic                     relu_q, relu_d, err_q, err_d, ov_q, ov_d;
    logic [7:0]               beat_q, beat_d, base_q, base_d;
    logic [2:0]               r_q, r_d;
    logic [FA_W-1:0]          fa_q, fa_d;
    logic [IA_W-1:0]          ia_q, ia_d;
    logic [PSUM_W-1:0]        opsum_q, opsum_d;
    logic signed [ELEM_W-1:0] filt_q [FILTER_DEPTH];
    logic signed [ELEM_W-1:0] filt_d [FILTER_DEPTH];
    logic signed [IE_W-1:0]   ifm_q  [IFMAP_DEPTH];
    logic signed [IE_W-1:0]   ifm_d  [IFMAP_DEPTH];
    logic [PSUM_W-1:0]        psum_q [PSUM_DEPTH];
    logic [PSUM_W-1:0]        psum_d [PSUM_DEPTH];

    logic [7:0]               fil_beats_s, tail_s, rq_s;
    logic [11:0]              prq_s;
    logic                     bad_cfg_s;
    logic signed [PR_W-1:0]   prod_s;
    int                       widx_s;

    // Filter is signed ELEM_W, ifmap entries are already zero-point corrected.
    function automatic logic [PSUM_W-1:0] relu_f(input logic en, input logic [PSUM_W-1:0] w);
        return (en && w[PSUM_W-1]) ? {PSUM_W{1'b0}} : w;
    endfunction

    assign fil_beats_s = 8'(p_q) * 8'(rs_q);
    assign tail_s      = 8'(rs_q - 3'd1) * 8'(cq_q);
    assign prq_s       = 12'(cfg_p) * 12'(cfg_rs) * 12'(cfg_q);
    assign rq_s        = 8'(cfg_rs) * 8'(cfg_q);
    assign bad_cfg_s   = (cfg_rs == 3'd0) || (cfg_p == 4'd0) || (cfg_q == 4'd0) || (cfg_f == 6'd0) ||
                         (32'(cfg_q) > PACK) || (32'(cfg_p) > PSUM_DEPTH) ||
                         (32'(prq_s) > FILTER_DEPTH) || (32'(rq_s) > IFMAP_DEPTH);
    assign prod_s      = filt_q[fa_q] * ifm_q[ia_q];

    assign bus.filter_ready = (state_q == S_FILT);
    assign bus.ifmap_ready  = (state_q == S_IFM);
    assign bus.ipsum_ready  = (state_q == S_IPS);
    assign bus.opsum_valid  = ov_q;
    assign bus.opsum        = opsum_q;
    assign busy             = (state_q != S_IDLE);
    assign cfg_err          = err_q;

    // Next-state, spad-write and datapath decode.
    always_comb begin
        state_d = state_q; rs_d = rs_q; p_d = p_q; cq_d = cq_q; f_d = f_q; relu_d = relu_q;
        err_d = err_q; ov_d = ov_q; beat_d = beat_q; base_d = base_q; c_d = c_q; r_d = r_q;
        po_d = po_q; fa_d = fa_q; ia_d = ia_q; col_d = col_q; opsum_d = opsum_q;
        filt_d = filt_q; ifm_d = ifm_q; psum_d = psum_q; widx_s = 0;
        case (state_q)
            S_IDLE: begin
                if (PE_en) begin
                    rs_d = cfg_rs; p_d = cfg_p; cq_d = cfg_q; f_d = cfg_f; relu_d = cfg_relu;
                    if (bad_cfg_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0; state_d = S_FILT; beat_d = 8'd0; base_d = 8'd0;
                        col_d = 6'd0; c_d = 4'd0; r_d = 3'd0; po_d = 4'd0;
                        fa_d = '0; ia_d = '0;
                    end
                end else begin
                    err_d = err_q;
                end
            end
            S_FILT: begin
                if (bus.filter_valid) begin
                    for (int k = 0; k < PACK; k++) begin
                        widx_s = int'(base_q) + k;
                        if (k < int'(cq_q) && widx_s < FILTER_DEPTH) begin
                            filt_d[FA_W'(widx_s)] = bus.filter[k*ELEM_W +: ELEM_W];
                        end else begin
                            widx_s = 0;
                        end
                    end
                    if (beat_q == fil_beats_s - 8'd1) begin
                        state_d = S_IFM; beat_d = 8'd0; base_d = 8'd0;
                    end else begin
                        beat_d = beat_q + 8'd1; base_d = base_q + 8'(cq_q);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            S_IFM: begin
                if (bus.ifmap_valid) begin
                    for (int k = 0; k < PACK; k++) begin
                        widx_s = int'(base_q) + k;
                        if (k < int'(cq_q) && widx_s < IFMAP_DEPTH) begin
                            ifm_d[IA_W'(widx_s)] = IE_W'({1'b0, bus.ifmap[k*ELEM_W +: ELEM_W]}) - IE_W'(IFMAP_ZP);
                        end else begin
                            widx_s = 0;
                        end
                    end
                    // Only the first column fills the whole window; later ones add one row.
                    if (col_q != 6'd0 || beat_q == 8'(rs_q) - 8'd1) begin
                        state_d = S_IPS; beat_d = 8'd0;
                    end else begin
                        beat_d = beat_q + 8'd1; base_d = base_q + 8'(cq_q);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            S_IPS: begin
                if (bus.ipsum_valid) begin
                    psum_d[PA_W'(beat_q)] = bus.ipsum;
                    if (beat_q == 8'(p_q) - 8'd1) begin
                        state_d = S_CONV; beat_d = 8'd0; c_d = 4'd0; r_d = 3'd0; po_d = 4'd0;
                        fa_d = '0; ia_d = '0;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            S_CONV: begin
                psum_d[PA_W'(po_q)] = psum_q[PA_W'(po_q)] + {{(PSUM_W-PR_W){prod_s[PR_W-1]}}, prod_s};
                fa_d = fa_q + FA_W'(1'b1);
                ia_d = ia_q + IA_W'(1'b1);
                if (c_q == cq_q - 4'd1) begin
                    c_d = 4'd0;
                    if (r_q == rs_q - 3'd1) begin
                        r_d = 3'd0; ia_d = '0;
                        if (po_q == p_q - 4'd1) begin
                            po_d = 4'd0; fa_d = '0; state_d = S_WR; ov_d = 1'b0;
                        end else begin
                            po_d = po_q + 4'd1;
                        end
                    end else begin
                        r_d = r_q + 3'd1;
                    end
                end else begin
                    c_d = c_q + 4'd1;
                end
            end
            S_WR: begin
                if (!ov_q) begin
                    ov_d = 1'b1; opsum_d = relu_f(relu_q, psum_q[PA_W'(po_q)]);
                end else if (bus.opsum_ready) begin
                    if (po_q == p_q - 4'd1) begin
                        ov_d = 1'b0; po_d = 4'd0; col_d = col_q + 6'd1;
                        if (col_q + 6'd1 == f_q) begin
                            state_d = S_IDLE;
                        end else begin
                            for (int i = 0; i < IFMAP_DEPTH; i++) begin
                                if (i < int'(tail_s) && i + int'(cq_q) < IFMAP_DEPTH) begin
                                    ifm_d[i] = ifm_q[IA_W'(i + int'(cq_q))];
                                end else begin
                                    ifm_d[i] = '0;
                                end
                            end
                            state_d = S_IFM; beat_d = 8'd0; base_d = tail_s;
                        end
                    end else begin
                        po_d = po_q + 4'd1;
                        opsum_d = relu_f(relu_q, psum_q[PA_W'(po_q + 4'd1)]);
                    end
                end else begin
                    ov_d = ov_q;
                end
            end
            default: begin
                state_d = S_IDLE; ov_d = 1'b0;
            end
        endcase
    end

    // State and spad registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE; rs_q <= 3'd0; p_q <= 4'd0; cq_q <= 4'd0; f_q <= 6'd0;
            relu_q <= 1'b0; err_q <= 1'b0; ov_q <= 1'b0; beat_q <= 8'd0; base_q <= 8'd0;
            c_q <= 4'd0; r_q <= 3'd0; po_q <= 4'd0; fa_q <= '0; ia_q <= '0; col_q <= 6'd0;
            opsum_q <= '0;
            filt_q <= '{default: '0}; ifm_q <= '{default: '0}; psum_q <= '{default: '0};
        end else begin
            state_q <= state_d; rs_q <= rs_d; p_q <= p_d; cq_q <= cq_d; f_q <= f_d;
            relu_q <= relu_d; err_q <= err_d; ov_q <= ov_d; beat_q <= beat_d; base_q <= base_d;
            c_q <= c_d; r_q <= r_d; po_q <= po_d; fa_q <= fa_d; ia_q <= ia_d; col_q <= col_d;
            opsum_q <= opsum_d;
            filt_q <= filt_d; ifm_q <= ifm_d; psum_q <= psum_d;
        end
    end
endmodule

// File: tb/tb_pe_rs_param.sv
// Directed bench for pe_rs_param: small jobs with hand-derived or sliding-window expected opsums.
module tb_pe_rs_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       PE_en;
    logic [2:0] cfg_rs;
    logic [3:0] cfg_p, cfg_q;
    logic [5:0] cfg_f;
    logic       cfg_relu;
    logic       busy, cfg_err;

    pe_rs_if #(.DATA_W(32)) bus ();

    pe_rs_param dut (
        .clk(clk), .rst(rst), .PE_en(PE_en), .cfg_rs(cfg_rs), .cfg_p(cfg_p), .cfg_q(cfg_q),
        .cfg_f(cfg_f), .cfg_relu(cfg_relu), .bus(bus), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  fw [8][7][4];
    logic [7:0]  iw [16][4];
    logic [31:0] ps [8][8];
    logic [31:0] last_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Direct sliding-window convolution for output column j, output channel po.
    function automatic logic [31:0] model(int j, int po, int rs, int q, bit relu);
        logic [31:0] acc;
        acc = ps[j][po];
        for (int r = 0; r < rs; r++)
            for (int c = 0; c < q; c++)
                acc = acc + 32'(int'($signed(fw[po][r][c])) * (int'(iw[j+r][c]) - 128));
        if (relu && acc[31]) acc = 32'd0;
        return acc;
    endfunction

    function automatic logic [31:0] pack_f(int po, int r, int q);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = (k < q) ? fw[po][r][k] : 8'($urandom);
        return w;
    endfunction

    function automatic logic [31:0] pack_i(int row, int q);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = (k < q) ? iw[row][k] : 8'($urandom);
        return w;
    endfunction

    function automatic logic rdy(int ch);
        case (ch)
            0:       return bus.filter_ready;
            1:       return bus.ifmap_ready;
            default: return bus.ipsum_ready;
        endcase
    endfunction

    task automatic send(input int ch, input logic [31:0] w, input bit stall);
        int n;
        n = 0;
        @(negedge clk);
        if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
        case (ch)
            0:       begin bus.filter = w; bus.filter_valid = 1'b1; end
            1:       begin bus.ifmap  = w; bus.ifmap_valid  = 1'b1; end
            default: begin bus.ipsum  = w; bus.ipsum_valid  = 1'b1; end
        endcase
        while (!rdy(ch) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("send_timeout", 32'(rdy(ch)), 32'd1);
        else @(posedge clk);
        #1;
        bus.filter_valid = 1'b0; bus.ifmap_valid = 1'b0; bus.ipsum_valid = 1'b0;
    endtask

    task automatic recv(input bit toggle, output logic [31:0] w, output int n);
        logic [31:0] hv;
        bit held, got;
        held = 1'b0; got = 1'b0; hv = '0; w = '0; n = 0;
        while (!got && n < 200) begin
            @(negedge clk); n++;
            bus.opsum_ready = toggle ? ~bus.opsum_ready : 1'b1;
            if (bus.opsum_valid) begin
                if (held) check("opsum_hold", bus.opsum, hv);
                if (bus.opsum_ready) begin
                    w = bus.opsum; got = 1'b1; @(posedge clk);
                end else begin
                    held = 1'b1; hv = bus.opsum;
                end
            end
        end
        if (!got) check("recv_timeout", 32'(got), 32'd1);
    endtask

    task automatic start(input int rs, input int p, input int q, input int f, input bit relu);
        @(negedge clk);
        cfg_rs = 3'(rs); cfg_p = 4'(p); cfg_q = 4'(q); cfg_f = 6'(f); cfg_relu = relu;
        PE_en = 1'b1;
        @(posedge clk); #1;
        PE_en = 1'b0;
    endtask

    task automatic run_job(input int rs, input int p, input int q, input int f,
                           input bit relu, input bit stall, input bit toggle, input bit abort);
        logic [31:0] w;
        int n;
        start(rs, p, q, f, relu);
        check("start_busy", 32'(busy), 32'd1);
        check("start_err", 32'(cfg_err), 32'd0);
        for (int po = 0; po < p; po++)
            for (int r = 0; r < rs; r++) send(0, pack_f(po, r, q), stall);
        for (int j = 0; j < f; j++) begin
            for (int b = 0; b < ((j == 0) ? rs : 1); b++)
                send(1, pack_i((j == 0) ? b : j + rs - 1, q), stall);
            check("ifm_beats", {30'd0, bus.ifmap_ready, bus.ipsum_ready}, 32'd1);
            for (int po = 0; po < p; po++) send(2, ps[j][po], stall);
            if (abort) return;
            for (int po = 0; po < p; po++) begin
                recv(toggle, w, n);
                last_w = w;
                check($sformatf("opsum_c%0d_p%0d", j, po), w, model(j, po, rs, q, relu));
                if (!toggle && po > 0) check("opsum_b2b", 32'(n), 32'd1);
            end
        end
        @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        check("end_valid", 32'(bus.opsum_valid), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rdy"}, {29'd0, bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready}, 32'd0);
        check({tag, "_ov"}, 32'(bus.opsum_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int ill [6][4];
        rst = 1'b1; PE_en = 1'b0; cfg_rs = 3'd0; cfg_p = 4'd0; cfg_q = 4'd0; cfg_f = 6'd0;
        cfg_relu = 1'b0; bus.filter = '0; bus.ifmap = '0; bus.ipsum = '0;
        bus.filter_valid = 1'b0; bus.ifmap_valid = 1'b0; bus.ipsum_valid = 1'b0; bus.opsum_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("rst");
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_opsum", bus.opsum, 32'd0);
        rst = 1'b0;

        // 10 + 1*1 + 2*2 + 3*3
        fw[0][0][0] = 8'd1; fw[0][1][0] = 8'd2; fw[0][2][0] = 8'd3;
        iw[0][0] = 8'd129; iw[1][0] = 8'd130; iw[2][0] = 8'd131;
        ps[0][0] = 32'd10;
        run_job(3, 1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("job1_hand", last_w, 32'd24);

        for (int po = 0; po < 2; po++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 4; c++) fw[po][r][c] = 8'($urandom_range(0, 127));
        for (int row = 0; row < 5; row++)
            for (int c = 0; c < 4; c++) iw[row][c] = 8'($urandom_range(0, 255));
        for (int j = 0; j < 3; j++)
            for (int po = 0; po < 2; po++) ps[j][po] = $urandom;
        run_job(3, 2, 4, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(3, 2, 4, 3, 1'b0, 1'b1, 1'b1, 1'b0);

        fw[0][0][0] = 8'd0; iw[0][0] = 8'd200; ps[0][0] = 32'h8000_0000;
        run_job(1, 1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("relu_on", last_w, 32'd0);
        run_job(1, 1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("relu_off", last_w, 32'h8000_0000);

        // rs, p, q, f
        ill = '{'{3, 9, 1, 1}, '{0, 1, 1, 1}, '{3, 1, 5, 1}, '{4, 1, 4, 1}, '{3, 8, 4, 1}, '{3, 1, 1, 0}};
        for (int t = 0; t < 6; t++) begin
            start(ill[t][0], ill[t][1], ill[t][2], ill[t][3], 1'b0);
            check($sformatf("cfg_err_%0d", t), 32'(cfg_err), 32'd1);
            @(negedge clk);
            check_quiet($sformatf("cfg_ill_%0d", t));
        end
        fw[0][0][0] = 8'd1; fw[0][1][0] = 8'd2; fw[0][2][0] = 8'd3;
        iw[0][0] = 8'd129; iw[1][0] = 8'd130; iw[2][0] = 8'd131; ps[0][0] = 32'd10;
        run_job(3, 1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cfg_recover", last_w, 32'd24);

        for (int po = 0; po < 2; po++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 4; c++) fw[po][r][c] = 8'($urandom_range(0, 127));
        for (int row = 0; row < 5; row++)
            for (int c = 0; c < 4; c++) iw[row][c] = 8'($urandom_range(0, 255));
        run_job(3, 2, 4, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("conv_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_quiet("midrst");
        check("midrst_opsum", bus.opsum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job(3, 2, 4, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
